// File: rtl/ext_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ext_bus_ctrl
//  Purpose  : Serialises CPU reads/writes into byte beats on the 8-bit pin bus,
//             with programmable read turnaround and ROM-write error response.
//  Revision : 1.0 - initial release
// ============================================================================
module ext_bus_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic              sel_ram,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              ready,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  input  logic [7:0]        bus_in,
  output logic [7:0]        bus_out,
  output logic              bus_oe,
  output logic              strobe,
  output logic              addr_data,
  output logic              rom_ram
);

  localparam int         c_AB        = (ADDR_W + 7) / 8;
  localparam int         c_DB        = DATA_W / 8;
  localparam logic [3:0] c_AB_LAST   = 4'(c_AB - 1);
  localparam logic [3:0] c_DB_LAST   = 4'(c_DB - 1);
  localparam logic [3:0] c_TURN_LAST = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;
  localparam logic       c_HAS_TURN  = (WAIT_CYC > 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_TURN  = 3'd2,
    S_DATA  = 3'd3,
    S_DONE  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [3:0]          r_cnt, w_cnt_nxt;
  logic                r_we, w_we_nxt;
  logic                r_sel, w_sel_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
  logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
  logic [c_AB*8-1:0]   w_addr_pad;
  logic [7:0]          w_abyte, w_dbyte;

  logic                r_busy, r_ready, r_err, r_oe, r_strobe, r_ad;
  logic [7:0]          r_bus_out;
  logic                w_busy, w_ready, w_err, w_oe, w_strobe, w_ad;
  logic [7:0]          w_bus_out;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_we_nxt    = r_we;
    w_sel_nxt   = r_sel;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_rdata_nxt = r_rdata;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_we_nxt    = we;
          w_sel_nxt   = sel_ram;
          w_addr_nxt  = addr;
          w_wdata_nxt = wdata;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        if (r_cnt == c_AB_LAST) begin
          w_cnt_nxt = 4'd0;
          if (r_we && !r_sel)  w_state_nxt = S_FAULT;
          else if (r_we)       w_state_nxt = S_DATA;
          else if (c_HAS_TURN) w_state_nxt = S_TURN;
          else                 w_state_nxt = S_DATA;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_TURN: begin
        if (r_cnt == c_TURN_LAST) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = S_DATA;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_DATA: begin
        // Read beats land in rdata as they arrive, LSB byte first.
        if (!r_we) begin
          for (int k = 0; k < c_DB; k++) begin
            if (r_cnt == 4'(k)) w_rdata_nxt[k*8 +: 8] = bus_in;
          end
        end
        if (r_cnt == c_DB_LAST) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they register in step with it.
  always_comb begin
    w_addr_pad               = '0;
    w_addr_pad[ADDR_W-1:0]   = w_addr_nxt;
    w_abyte                  = 8'h00;
    w_dbyte                  = 8'h00;
    for (int k = 0; k < c_AB; k++) begin
      if (w_cnt_nxt == 4'(k)) w_abyte = w_addr_pad[k*8 +: 8];
    end
    for (int k = 0; k < c_DB; k++) begin
      if (w_cnt_nxt == 4'(k)) w_dbyte = w_wdata_nxt[k*8 +: 8];
    end

    w_busy    = 1'b0;
    w_ready   = 1'b0;
    w_err     = 1'b0;
    w_oe      = 1'b0;
    w_strobe  = 1'b0;
    w_ad      = 1'b0;
    w_bus_out = 8'h00;
    case (w_state_nxt)
      S_ADDR: begin
        w_busy    = 1'b1;
        w_bus_out = w_abyte;
        w_oe      = 1'b1;
        w_strobe  = 1'b1;
        w_ad      = 1'b1;
      end
      S_TURN: w_busy = 1'b1;
      S_DATA: begin
        w_busy   = 1'b1;
        w_strobe = 1'b1;
        if (w_we_nxt) begin
          w_bus_out = w_dbyte;
          w_oe      = 1'b1;
        end
      end
      S_DONE:  w_ready = 1'b1;
      S_FAULT: w_err   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_we      <= 1'b0;
      r_sel     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_busy    <= 1'b0;
      r_ready   <= 1'b0;
      r_err     <= 1'b0;
      r_oe      <= 1'b0;
      r_strobe  <= 1'b0;
      r_ad      <= 1'b0;
      r_bus_out <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_we      <= w_we_nxt;
      r_sel     <= w_sel_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_rdata   <= w_rdata_nxt;
      r_busy    <= w_busy;
      r_ready   <= w_ready;
      r_err     <= w_err;
      r_oe      <= w_oe;
      r_strobe  <= w_strobe;
      r_ad      <= w_ad;
      r_bus_out <= w_bus_out;
    end
  end

  assign busy      = r_busy;
  assign ready     = r_ready;
  assign err       = r_err;
  assign rdata     = r_rdata;
  assign bus_out   = r_bus_out;
  assign bus_oe    = r_oe;
  assign strobe    = r_strobe;
  assign addr_data = r_ad;
  assign rom_ram   = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_ext_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ext_bus_ctrl
//  Purpose  : Vector-table bench for ext_bus_ctrl, default and 12/16/0 configs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ext_bus_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default configuration instance
  logic       a_rst, a_req, a_we, a_sel;
  logic [7:0] a_addr, a_wdata, a_bi, a_rd, a_bo;
  logic       a_busy, a_ready, a_err, a_oe, a_stb, a_ad, a_rom;

  ext_bus_ctrl u_dut_a (
    .clk(clk), .reset(a_rst), .req(a_req), .we(a_we), .sel_ram(a_sel),
    .addr(a_addr), .wdata(a_wdata), .busy(a_busy), .ready(a_ready),
    .err(a_err), .rdata(a_rd), .bus_in(a_bi), .bus_out(a_bo),
    .bus_oe(a_oe), .strobe(a_stb), .addr_data(a_ad), .rom_ram(a_rom)
  );

  // Two address beats, two data beats, no turnaround
  logic        b_rst, b_req, b_we, b_sel;
  logic [11:0] b_addr;
  logic [15:0] b_wdata, b_rd;
  logic [7:0]  b_bi, b_bo;
  logic        b_busy, b_ready, b_err, b_oe, b_stb, b_ad, b_rom;

  ext_bus_ctrl #(.ADDR_W(12), .DATA_W(16), .WAIT_CYC(0)) u_dut_b (
    .clk(clk), .reset(b_rst), .req(b_req), .we(b_we), .sel_ram(b_sel),
    .addr(b_addr), .wdata(b_wdata), .busy(b_busy), .ready(b_ready),
    .err(b_err), .rdata(b_rd), .bus_in(b_bi), .bus_out(b_bo),
    .bus_oe(b_oe), .strobe(b_stb), .addr_data(b_ad), .rom_ram(b_rom)
  );

  // flags = {busy, ready, err, rom_ram, bus_oe, strobe, addr_data}
  typedef struct {
    logic       rst, req, we, sel;
    logic [7:0] addr, wdata, bi;
    logic [6:0] fl;
    logic [7:0] bo, rd;
  } vec_t;

  typedef struct {
    logic        rst, req, we, sel;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [7:0]  bi;
    logic [6:0]  fl;
    logic [7:0]  bo;
    logic [15:0] rd;
  } wvec_t;

  function automatic vec_t mk(input logic rst, req, we, sel,
                              input logic [7:0] a, w, bi,
                              input logic [6:0] fl, input logic [7:0] bo, rd);
    vec_t v;
    v.rst = rst; v.req = req; v.we = we; v.sel = sel;
    v.addr = a; v.wdata = w; v.bi = bi; v.fl = fl; v.bo = bo; v.rd = rd;
    return v;
  endfunction

  function automatic wvec_t mkw(input logic rst, req, we, sel,
                                input logic [11:0] a, input logic [15:0] w,
                                input logic [7:0] bi, input logic [6:0] fl,
                                input logic [7:0] bo, input logic [15:0] rd);
    wvec_t v;
    v.rst = rst; v.req = req; v.we = we; v.sel = sel;
    v.addr = a; v.wdata = w; v.bi = bi; v.fl = fl; v.bo = bo; v.rd = rd;
    return v;
  endfunction

  vec_t  tv[30];
  wvec_t wv[12];
  int    n_checks = 0;
  int    n_fail   = 0;
  logic [22:0] act_a, exp_a;
  logic [30:0] act_b, exp_b;

  initial begin
    // Default read, write, ROM write, back-to-back reads, reset in TURN
    tv[0]  = mk(1,0,0,0, 8'h00,8'h00,8'h00, 7'b0000000, 8'h00, 8'h00);
    tv[1]  = mk(0,1,0,1, 8'h5A,8'h00,8'h00, 7'b1001111, 8'h5A, 8'h00);
    tv[2]  = mk(0,0,0,1, 8'hFF,8'h00,8'h00, 7'b1001000, 8'h00, 8'h00);
    tv[3]  = mk(0,0,0,1, 8'hFF,8'h00,8'h00, 7'b1001010, 8'h00, 8'h00);
    tv[4]  = mk(0,0,0,1, 8'hFF,8'h00,8'hC3, 7'b0101000, 8'h00, 8'hC3);
    tv[5]  = mk(0,0,0,1, 8'h00,8'h00,8'h00, 7'b0001000, 8'h00, 8'hC3);
    tv[6]  = mk(0,1,1,1, 8'h10,8'hA5,8'h00, 7'b1001111, 8'h10, 8'hC3);
    tv[7]  = mk(0,0,0,0, 8'h77,8'h00,8'h00, 7'b1001110, 8'hA5, 8'hC3);
    tv[8]  = mk(0,0,0,0, 8'h00,8'h00,8'h00, 7'b0101000, 8'h00, 8'hC3);
    tv[9]  = mk(0,0,0,0, 8'h00,8'h00,8'h00, 7'b0001000, 8'h00, 8'hC3);
    tv[10] = mk(0,1,1,0, 8'h33,8'h77,8'h00, 7'b1000111, 8'h33, 8'hC3);
    tv[11] = mk(0,0,0,0, 8'h00,8'h00,8'hEE, 7'b0010000, 8'h00, 8'hC3);
    tv[12] = mk(0,0,0,0, 8'h00,8'h00,8'hEE, 7'b0000000, 8'h00, 8'hC3);
    tv[13] = mk(0,1,0,1, 8'h01,8'h00,8'h00, 7'b1001111, 8'h01, 8'hC3);
    tv[14] = mk(0,1,1,0, 8'h02,8'h00,8'h00, 7'b1001000, 8'h00, 8'hC3);
    tv[15] = mk(0,1,0,1, 8'h03,8'h00,8'h00, 7'b1001010, 8'h00, 8'hC3);
    tv[16] = mk(0,1,0,1, 8'h04,8'h00,8'h66, 7'b0101000, 8'h00, 8'h66);
    tv[17] = mk(0,1,0,1, 8'h06,8'h00,8'h00, 7'b0001000, 8'h00, 8'h66);
    tv[18] = mk(0,1,0,1, 8'h06,8'h00,8'h00, 7'b1001111, 8'h06, 8'h66);
    tv[19] = mk(0,0,0,1, 8'h07,8'h00,8'h00, 7'b1001000, 8'h00, 8'h66);
    tv[20] = mk(0,0,0,1, 8'h08,8'h00,8'h00, 7'b1001010, 8'h00, 8'h66);
    tv[21] = mk(0,0,0,1, 8'h08,8'h00,8'h99, 7'b0101000, 8'h00, 8'h99);
    tv[22] = mk(0,0,0,1, 8'h00,8'h00,8'h00, 7'b0001000, 8'h00, 8'h99);
    tv[23] = mk(0,1,0,1, 8'h42,8'h00,8'h00, 7'b1001111, 8'h42, 8'h99);
    tv[24] = mk(0,0,0,1, 8'h00,8'h00,8'h00, 7'b1001000, 8'h00, 8'h99);
    tv[25] = mk(1,0,0,1, 8'h00,8'h00,8'h11, 7'b0000000, 8'h00, 8'h00);
    tv[26] = mk(0,1,0,1, 8'h24,8'h00,8'h00, 7'b1001111, 8'h24, 8'h00);
    tv[27] = mk(0,0,0,1, 8'h00,8'h00,8'h00, 7'b1001000, 8'h00, 8'h00);
    tv[28] = mk(0,0,0,1, 8'h00,8'h00,8'h00, 7'b1001010, 8'h00, 8'h00);
    tv[29] = mk(0,0,0,1, 8'h00,8'h00,8'h5E, 7'b0101000, 8'h00, 8'h5E);

    // Wide config: read 0xABC, then write 0xBEEF to 0x123
    wv[0]  = mkw(1,0,0,0, 12'h000,16'h0000,8'h00, 7'b0000000, 8'h00, 16'h0000);
    wv[1]  = mkw(0,1,0,1, 12'hABC,16'h0000,8'h00, 7'b1001111, 8'hBC, 16'h0000);
    wv[2]  = mkw(0,0,0,1, 12'h000,16'h0000,8'h00, 7'b1001111, 8'h0A, 16'h0000);
    wv[3]  = mkw(0,0,0,1, 12'h000,16'h0000,8'h00, 7'b1001010, 8'h00, 16'h0000);
    wv[4]  = mkw(0,0,0,1, 12'h000,16'h0000,8'h34, 7'b1001010, 8'h00, 16'h0034);
    wv[5]  = mkw(0,0,0,1, 12'h000,16'h0000,8'h12, 7'b0101000, 8'h00, 16'h1234);
    wv[6]  = mkw(0,0,0,1, 12'h000,16'h0000,8'h00, 7'b0001000, 8'h00, 16'h1234);
    wv[7]  = mkw(0,1,1,1, 12'h123,16'hBEEF,8'h00, 7'b1001111, 8'h23, 16'h1234);
    wv[8]  = mkw(0,0,0,0, 12'hFFF,16'h0000,8'h00, 7'b1001111, 8'h01, 16'h1234);
    wv[9]  = mkw(0,0,0,0, 12'hFFF,16'h0000,8'h00, 7'b1001110, 8'hEF, 16'h1234);
    wv[10] = mkw(0,0,0,0, 12'hFFF,16'h0000,8'h00, 7'b1001110, 8'hBE, 16'h1234);
    wv[11] = mkw(0,0,0,0, 12'hFFF,16'h0000,8'h00, 7'b0101000, 8'h00, 16'h1234);

    a_rst = 1'b1; a_req = 1'b0; a_we = 1'b0; a_sel = 1'b0;
    a_addr = 8'h00; a_wdata = 8'h00; a_bi = 8'h00;
    b_rst = 1'b1; b_req = 1'b0; b_we = 1'b0; b_sel = 1'b0;
    b_addr = 12'h000; b_wdata = 16'h0000; b_bi = 8'h00;

    for (int i = 0; i < 30; i++) begin
      a_rst = tv[i].rst; a_req = tv[i].req; a_we = tv[i].we; a_sel = tv[i].sel;
      a_addr = tv[i].addr; a_wdata = tv[i].wdata; a_bi = tv[i].bi;
      @(posedge clk);
      #1;
      act_a = {a_busy, a_ready, a_err, a_rom, a_oe, a_stb, a_ad, a_bo, a_rd};
      exp_a = {tv[i].fl, tv[i].bo, tv[i].rd};
      n_checks++;
      if (act_a !== exp_a) begin
        n_fail++;
        $display("FAIL narrow_vec%0d: got flags=%b bus_out=%h rdata=%h, expected flags=%b bus_out=%h rdata=%h",
                 i, act_a[22:16], act_a[15:8], act_a[7:0], exp_a[22:16], exp_a[15:8], exp_a[7:0]);
      end
    end

    for (int i = 0; i < 12; i++) begin
      b_rst = wv[i].rst; b_req = wv[i].req; b_we = wv[i].we; b_sel = wv[i].sel;
      b_addr = wv[i].addr; b_wdata = wv[i].wdata; b_bi = wv[i].bi;
      @(posedge clk);
      #1;
      act_b = {b_busy, b_ready, b_err, b_rom, b_oe, b_stb, b_ad, b_bo, b_rd};
      exp_b = {wv[i].fl, wv[i].bo, wv[i].rd};
      n_checks++;
      if (act_b !== exp_b) begin
        n_fail++;
        $display("FAIL wide_vec%0d: got flags=%b bus_out=%h rdata=%h, expected flags=%b bus_out=%h rdata=%h",
                 i, act_b[30:24], act_b[23:16], act_b[15:0], exp_b[30:24], exp_b[23:16], exp_b[15:0]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
